counter_updown_mod: RTL



---
 rtl/counter_updown_mod.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_mod
// Description : Up/down counter over 0..MODULUS-1 with synchronous clamped
//               load, wrap or saturate at the boundaries, combinational
//               terminal count and a registered one-cycle wrap pulse.
//               Optional enabled-cycle prescaler: define COUNTER_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_updown_mod #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] result,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("counter_updown_mod: MODULUS must lie in 2..2**WIDTH");
    end

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("counter_updown_mod: PRESCALE must be at least 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             step;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;

    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == '0);

    // A full-range modulus cannot be exceeded, so the clamp only exists
    // when some load values lie above MAX.
    if (longint'(MODULUS) < (64'd1 << WIDTH)) begin : g_clamp
        assign load_clamped = (load_val > MAX) ? MAX : load_val;
    end else begin : g_no_clamp
        assign load_clamped = load_val;
    end

    // ------------------------------------------------------------------
    // Step qualification
    // ------------------------------------------------------------------
`ifdef COUNTER_PRESCALE_EN
    localparam int             DIV_W    = $clog2(PRESCALE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (load) begin
            div_d = '0;
        end else if (ena) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign step = ena && !load && (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign step = ena && !load;
`endif

    // ------------------------------------------------------------------
    // Next-state: load > step > hold
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (up_dn) begin
                if (!at_max) begin
                    count_d = count_q + 1'b1;
                end else if (!sat_mode) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - 1'b1;
                end else if (!sat_mode) begin
                    count_d = MAX;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign result = count_q;
    assign wrap   = wrap_q;
    assign tc     = up_dn ? at_max : at_zero;

endmodule
`default_nettype wire
